// File: rtl/regfile_hilo.sv
// 32 x 32-bit general-purpose register file with HI/LO pair, same-cycle write bypass
// on every read port, and a counter of committed non-zero GPR writes.
module regfile_hilo #(
    parameter int WB_TO_RF_WD = 105
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [4:0]             raddr1,
    input  logic [4:0]             raddr2,
    output logic [31:0]            rdata1,
    output logic [31:0]            rdata2,
    output logic [31:0]            hi_rdata,
    output logic [31:0]            lo_rdata,
    output logic [31:0]            wr_count
);

    logic [63:0] hl_wdata;
    logic [1:0]  hl_waddr;
    logic        hl_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign {hl_wdata, hl_waddr, hl_we, rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus[104:0];

    logic gpr_wr;
    logic hi_wr;
    logic lo_wr;

    assign gpr_wr = rf_we && (rf_waddr != 5'd0);
    assign hi_wr  = hl_we && hl_waddr[1];
    assign lo_wr  = hl_we && hl_waddr[0];

    logic [31:0] gpr_q [32];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        wr_count_d = wr_count_q;
        if (hi_wr) hi_d = hl_wdata[63:32];
        if (lo_wr) lo_d = hl_wdata[31:0];
        if (gpr_wr) wr_count_d = wr_count_q + 32'd1;
    end

    // GPR0 is cleared on reset and never written, so it always reads back as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            wr_count_q <= '0;
        end else begin
            if (gpr_wr) gpr_q[rf_waddr] <= rf_wdata;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            wr_count_q <= wr_count_d;
        end
    end

    function automatic logic [31:0] gpr_read(input logic [4:0] addr);
        logic [31:0] val;
        val = '0;
        if (addr != 5'd0) begin
            if (gpr_wr && (addr == rf_waddr)) val = rf_wdata;
            else                               val = gpr_q[addr];
        end
        return val;
    endfunction

    assign rdata1   = gpr_read(raddr1);
    assign rdata2   = gpr_read(raddr2);
    // The next-state values double as the HI/LO bypass path.
    assign hi_rdata = hi_d;
    assign lo_rdata = lo_d;
    assign wr_count = wr_count_q;

endmodule
